// File: rtl/square_pos_ctrl.sv
// Frame-synchronous square-centre controller: synchronises the push buttons and
// moves (cx, cy) with press / hold / auto-repeat timing once per frame.
module square_pos_ctrl #(
    parameter int WIDTH        = 96,
    parameter int HEIGHT       = 64,
    parameter int HALF         = 6,
    parameter int STEP         = 1,
    parameter int REPEAT_DELAY = 8,
    parameter int REPEAT_RATE  = 2,
    parameter int HOME_X       = 48,
    parameter int HOME_Y       = 32
) (
    input  logic        clk25,
    input  logic        rst_n,
    input  logic [12:0] pixel_index,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_centre,
    output logic [6:0]  cx,
    output logic [5:0]  cy,
    output logic        frame_tick,
    output logic        moving,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        HOME   = 2'd3
    } state_t;

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic signed [8:0] CX_MIN = 9'(HALF);
    localparam logic signed [8:0] CX_MAX = 9'(WIDTH - 1 - HALF);
    localparam logic signed [8:0] CY_MIN = 9'(HALF);
    localparam logic signed [8:0] CY_MAX = 9'(HEIGHT - 1 - HALF);
    localparam logic signed [8:0] STEP_S = 9'(STEP);

    // Button vector order: {centre, right, left, down, up}
    logic [4:0] btn_raw;
    logic [4:0] sync1_q, sync1_d;
    logic [4:0] sync2_q, sync2_d;

    logic prev_idx_zero_q, prev_idx_zero_d;
    logic frame_tick_q, frame_tick_d;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       cx_q, cx_d;
    logic [5:0]       cy_q, cy_d;
    logic             moving_q, moving_d;

    logic               up_s, down_s, left_s, right_s, centre_s;
    logic signed [8:0]  dx, dy;
    logic               any_dir;
    logic signed [8:0]  cx_sum, cy_sum;
    logic signed [8:0]  cx_new, cy_new;
    logic               idx_zero;

    assign btn_raw = {btn_centre, btn_right, btn_left, btn_down, btn_up};

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    assign up_s     = sync2_q[0];
    assign down_s   = sync2_q[1];
    assign left_s   = sync2_q[2];
    assign right_s  = sync2_q[3];
    assign centre_s = sync2_q[4];

    // A frame starts on the first sample of index 0 after a nonzero sample.
    assign idx_zero = (pixel_index == 13'd0);

    always_comb begin
        prev_idx_zero_d = idx_zero;
        frame_tick_d    = idx_zero && !prev_idx_zero_q;
    end

    always_comb begin
        dx = 9'sd0;
        dy = 9'sd0;
        if (right_s && !left_s) dx = STEP_S;
        else if (left_s && !right_s) dx = -STEP_S;
        if (down_s && !up_s) dy = STEP_S;
        else if (up_s && !down_s) dy = -STEP_S;
    end

    assign any_dir = (dx != 9'sd0) || (dy != 9'sd0);

    // Saturating move, each axis clamped on its own.
    always_comb begin
        cx_sum = $signed({2'b00, cx_q}) + dx;
        cy_sum = $signed({3'b000, cy_q}) + dy;
        cx_new = cx_sum;
        cy_new = cy_sum;
        if (cx_sum < CX_MIN) cx_new = CX_MIN;
        else if (cx_sum > CX_MAX) cx_new = CX_MAX;
        if (cy_sum < CY_MIN) cy_new = CY_MIN;
        else if (cy_sum > CY_MAX) cy_new = CY_MAX;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        if (frame_tick_q) begin
            if (centre_s || state_q == HOME) begin
                // HOME is resolved on the same tick and never held.
                cx_d    = 7'(HOME_X);
                cy_d    = 6'(HOME_Y);
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (any_dir) begin
                            cx_d    = 7'(cx_new);
                            cy_d    = 6'(cy_new);
                            cnt_d   = '0;
                            state_d = HOLD;
                        end
                    end
                    HOLD: begin
                        if (!any_dir) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
                            cx_d    = 7'(cx_new);
                            cy_d    = 6'(cy_new);
                            cnt_d   = '0;
                            state_d = REPEAT;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (!any_dir) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else if (cnt_q == CNT_W'(REPEAT_RATE - 1)) begin
                            cx_d  = 7'(cx_new);
                            cy_d  = 6'(cy_new);
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
        moving_d = (state_d == HOLD) || (state_d == REPEAT);
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q         <= '0;
            sync2_q         <= '0;
            prev_idx_zero_q <= 1'b0;
            frame_tick_q    <= 1'b0;
            state_q         <= IDLE;
            cnt_q           <= '0;
            cx_q            <= 7'(HOME_X);
            cy_q            <= 6'(HOME_Y);
            moving_q        <= 1'b0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            prev_idx_zero_q <= prev_idx_zero_d;
            frame_tick_q    <= frame_tick_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            cx_q            <= cx_d;
            cy_q            <= cy_d;
            moving_q        <= moving_d;
        end
    end

    assign cx         = cx_q;
    assign cy         = cy_q;
    assign frame_tick = frame_tick_q;
    assign moving     = moving_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_square_pos_ctrl.sv
// Directed bench for square_pos_ctrl; frames are shortened to a few cycles since
// only the nonzero-to-zero transition of pixel_index marks a frame boundary.
module tb_square_pos_ctrl;

    logic        clk25;
    logic        rst_n;
    logic [12:0] pixel_index;
    logic        btn_up, btn_down, btn_left, btn_right, btn_centre;
    logic [6:0]  cx;
    logic [5:0]  cy;
    logic        frame_tick;
    logic        moving;
    logic [1:0]  dbg_state;

    int n_checks;
    int n_fail;

    square_pos_ctrl dut (
        .clk25       (clk25),
        .rst_n       (rst_n),
        .pixel_index (pixel_index),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_centre  (btn_centre),
        .cx          (cx),
        .cy          (cy),
        .frame_tick  (frame_tick),
        .moving      (moving),
        .dbg_state   (dbg_state)
    );

    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    // Moves made after k ticks of a held direction: one on press, one after
    // REPEAT_DELAY=8 more ticks, then one every REPEAT_RATE=2 ticks.
    function automatic int moves(input int k);
        if (k <= 0) return 0;
        if (k < 9) return 1;
        return 2 + (k - 9) / 2;
    endfunction

    // Button vector order: {centre, right, left, down, up}; waits until synced.
    task automatic set_btns(input logic [4:0] b);
        @(negedge clk25);
        {btn_centre, btn_right, btn_left, btn_down, btn_up} = b;
        repeat (3) @(negedge clk25);
    endtask

    // One frame boundary; returns at the negedge after cx/cy have updated.
    task automatic frame();
        @(negedge clk25) pixel_index = 13'd0;
        @(negedge clk25) pixel_index = 13'd1;
        @(negedge clk25) pixel_index = 13'd2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {btn_centre, btn_right, btn_left, btn_down, btn_up} = 5'b0;
        pixel_index = 13'd5;
        repeat (3) @(negedge clk25);
        rst_n = 1'b1;
        @(negedge clk25);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (cx !== 7'd48 || cy !== 6'd32) begin
            n_fail++;
            $display("FAIL reset_pos: got cx=%0d cy=%0d, required 48/32", cx, cy);
        end
        n_checks++;
        if (moving !== 1'b0 || frame_tick !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got moving=%b tick=%b state=%0d, required 0/0/0",
                     moving, frame_tick, dbg_state);
        end
        set_btns(5'b01000);
        frame();
        frame();
        n_checks++;
        if (cx !== 7'd49 || moving !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_move: got cx=%0d moving=%b, required 49/1", cx, moving);
        end
        // Assert reset between edges while frame_tick is high.
        @(negedge clk25) pixel_index = 13'd0;
        @(negedge clk25) pixel_index = 13'd1;
        n_checks++;
        if (frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL tick_before_async: got %b, required 1", frame_tick);
        end
        #5 rst_n = 1'b0;
        #1;
        n_checks++;
        if (cx !== 7'd48 || cy !== 6'd32 || moving !== 1'b0 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got cx=%0d cy=%0d moving=%b tick=%b, required 48/32/0/0",
                     cx, cy, moving, frame_tick);
        end
        @(negedge clk25);
        rst_n = 1'b1;
        pixel_index = 13'd7;
        repeat (3) @(negedge clk25);
        frame();
        n_checks++;
        if (cx !== 7'd49 || dbg_state !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_discards_repeat: got cx=%0d state=%0d, required 49/1",
                     cx, dbg_state);
        end
    endtask

    task automatic test_right_hold();
        do_reset();
        set_btns(5'b01000);
        for (int k = 1; k <= 20; k++) begin
            frame();
            n_checks++;
            if (cx !== 7'(48 + moves(k)) || cy !== 6'd32 || moving !== 1'b1) begin
                n_fail++;
                $display("FAIL right_hold tick %0d: got cx=%0d cy=%0d moving=%b, required %0d/32/1",
                         k, cx, cy, moving, 48 + moves(k));
            end
        end
    endtask

    task automatic test_left_saturate();
        int exp_x;
        do_reset();
        set_btns(5'b00100);
        for (int k = 1; k <= 100; k++) begin
            frame();
            exp_x = 48 - moves(k);
            if (exp_x < 6) exp_x = 6;
            n_checks++;
            if (cx !== 7'(exp_x) || cy !== 6'd32) begin
                n_fail++;
                $display("FAIL left_saturate tick %0d: got cx=%0d cy=%0d, required %0d/32",
                         k, cx, cy, exp_x);
            end
        end
    endtask

    task automatic test_cancel();
        do_reset();
        set_btns(5'b01011);
        for (int k = 1; k <= 20; k++) begin
            frame();
            n_checks++;
            if (cx !== 7'(48 + moves(k)) || cy !== 6'd32) begin
                n_fail++;
                $display("FAIL cancel tick %0d: got cx=%0d cy=%0d, required %0d/32",
                         k, cx, cy, 48 + moves(k));
            end
        end
    endtask

    task automatic test_centre();
        do_reset();
        set_btns(5'b00010);
        for (int k = 1; k <= 12; k++) frame();
        n_checks++;
        if (cy !== 6'd35 || moving !== 1'b1 || dbg_state !== 2'd2) begin
            n_fail++;
            $display("FAIL down_repeat: got cy=%0d moving=%b state=%0d, required 35/1/2",
                     cy, moving, dbg_state);
        end
        set_btns(5'b10010);
        frame();
        n_checks++;
        if (cx !== 7'd48 || cy !== 6'd32 || moving !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL centre_home: got cx=%0d cy=%0d moving=%b state=%0d, required 48/32/0/0",
                     cx, cy, moving, dbg_state);
        end
        set_btns(5'b00010);
        frame();
        n_checks++;
        if (cy !== 6'd33 || moving !== 1'b1 || dbg_state !== 2'd1) begin
            n_fail++;
            $display("FAIL restart_move: got cy=%0d moving=%b state=%0d, required 33/1/1",
                     cy, moving, dbg_state);
        end
        frame();
        n_checks++;
        if (cy !== 6'd33) begin
            n_fail++;
            $display("FAIL restart_hold: got cy=%0d, required 33", cy);
        end
    endtask

    task automatic test_frame_tick();
        do_reset();
        @(negedge clk25) pixel_index = 13'd6143;
        @(negedge clk25) pixel_index = 13'd0;
        n_checks++;
        if (frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_on_6143: got %b, required 0", frame_tick);
        end
        @(negedge clk25);
        n_checks++;
        if (frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL tick_on_zero: got %b, required 1", frame_tick);
        end
        @(negedge clk25) pixel_index = 13'd1;
        n_checks++;
        if (frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_zero_held: got %b, required 0", frame_tick);
        end
        @(negedge clk25);
        n_checks++;
        if (frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_on_one: got %b, required 0", frame_tick);
        end
        // A short press that ends before the next frame boundary is ignored.
        btn_right = 1'b1;
        repeat (3) @(negedge clk25);
        btn_right = 1'b0;
        repeat (4) @(negedge clk25);
        frame();
        n_checks++;
        if (cx !== 7'd48 || moving !== 1'b0) begin
            n_fail++;
            $display("FAIL short_press: got cx=%0d moving=%b, required 48/0", cx, moving);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        pixel_index = 13'd5;
        {btn_centre, btn_right, btn_left, btn_down, btn_up} = 5'b0;
        test_reset();
        test_right_hold();
        test_left_saturate();
        test_cancel();
        test_centre();
        test_frame_tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
